// File: rtl/vga_fb_arbiter_if.sv
// Signal bundle between the VGA timing/pixel-writer side and the frame-buffer
// arbiter: scan position, writer handshake, RAM port and display outputs.
interface vga_fb_arbiter_if #(
  parameter int DATA_W = 12,
  parameter int ADDR_W = 17
);
  logic              pclk;
  logic              DE;
  logic [9:0]        x_pixel;
  logic [9:0]        y_pixel;
  logic              v_sync;
  logic              wr_valid;
  logic              wr_ready;
  logic [ADDR_W-1:0] wr_addr;
  logic [DATA_W-1:0] wr_data;
  logic              wr_frame_done;
  logic              mem_en;
  logic              mem_we;
  logic [ADDR_W:0]   mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic [DATA_W-1:0] mem_rdata;
  logic [DATA_W-1:0] rgb_data;
  logic              disp_bank;
  logic              frame_swapped;
  logic              overrun;

  modport master (
    output pclk, DE, x_pixel, y_pixel, v_sync,
    output wr_valid, wr_addr, wr_data, wr_frame_done,
    output mem_rdata,
    input  wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
    input  rgb_data, disp_bank, frame_swapped, overrun
  );

  modport slave (
    input  pclk, DE, x_pixel, y_pixel, v_sync,
    input  wr_valid, wr_addr, wr_data, wr_frame_done,
    input  mem_rdata,
    output wr_ready, mem_en, mem_we, mem_addr, mem_wdata,
    output rgb_data, disp_bank, frame_swapped, overrun
  );
endinterface

// File: rtl/vga_fb_arbiter.sv
// Single-port frame-buffer arbiter: display reads own the cycle after each
// pixel tick, writer fills the other cycles; double-buffered banks swap at v_sync.
module vga_fb_arbiter #(
  parameter int DATA_W = 12,
  parameter int FB_W   = 320,
  parameter int FB_H   = 240,
  parameter int ADDR_W = 17
) (
  input logic            clk,
  input logic            reset,
  vga_fb_arbiter_if.slave bus
);

  localparam int unsigned FB_PIX = FB_W * FB_H;

  typedef enum logic {
    S_IDLE,
    S_PEND
  } swap_t;

  swap_t state;
  swap_t state_nx;

  logic bank;
  logic bank_nx;
  logic swap_go;
  logic ovr_go;
  logic vs_q;
  logic vs_fall;

  logic rd1_v;
  logic rd1_de;
  logic rd2_v;
  logic rd2_de;

  logic wr_fire;
  logic wr_ok;
  logic [ADDR_W-1:0] rd_addr;

  logic              en_q;
  logic              we_q;
  logic [ADDR_W:0]   addr_q;
  logic [DATA_W-1:0] wdata_q;
  logic [DATA_W-1:0] rgb_q;
  logic              swp_q;
  logic              ovr_q;

  logic unused;
  assign unused = ^{bus.x_pixel[0], bus.y_pixel[0]};

  assign vs_fall = vs_q & ~bus.v_sync;

  // Never ready on a tick: the following cycle belongs to the display read.
  assign bus.wr_ready = ~reset & ~bus.pclk & (state == S_IDLE);
  assign wr_fire      = bus.wr_valid & bus.wr_ready;
  assign wr_ok        = 32'(bus.wr_addr) < FB_PIX;

  assign rd_addr = ADDR_W'(bus.y_pixel[9:1]) * ADDR_W'(FB_W)
                 + ADDR_W'(bus.x_pixel[9:1]);

  always_comb begin
    state_nx = state;
    bank_nx  = bank;
    swap_go  = 1'b0;
    ovr_go   = 1'b0;
    case (state)
      S_IDLE: begin
        if (bus.wr_frame_done) begin
          state_nx = S_PEND;
        end
      end
      S_PEND: begin
        ovr_go = bus.wr_frame_done;
        if (vs_fall) begin
          state_nx = S_IDLE;
          bank_nx  = ~bank;
          swap_go  = 1'b1;
        end
      end
      default: state_nx = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state <= S_IDLE;
      bank  <= 1'b0;
    end else begin
      state <= state_nx;
      bank  <= bank_nx;
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      vs_q    <= 1'b1;
      swp_q   <= 1'b0;
      ovr_q   <= 1'b0;
      rd1_v   <= 1'b0;
      rd1_de  <= 1'b0;
      rd2_v   <= 1'b0;
      rd2_de  <= 1'b0;
      rgb_q   <= '0;
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
    end else begin
      vs_q   <= bus.v_sync;
      swp_q  <= swap_go;
      ovr_q  <= ovr_go;
      rd1_v  <= bus.pclk;
      rd1_de <= bus.pclk & bus.DE;
      rd2_v  <= rd1_v;
      rd2_de <= rd1_de;
      if (rd2_v) begin
        rgb_q <= rd2_de ? bus.mem_rdata : '0;
      end
      en_q    <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      if (bus.pclk & bus.DE) begin
        en_q   <= 1'b1;
        addr_q <= {bank, rd_addr};
      end else if (wr_fire & wr_ok) begin
        en_q    <= 1'b1;
        we_q    <= 1'b1;
        addr_q  <= {~bank, bus.wr_addr};
        wdata_q <= bus.wr_data;
      end
    end
  end

  assign bus.mem_en        = en_q;
  assign bus.mem_we        = we_q;
  assign bus.mem_addr      = addr_q;
  assign bus.mem_wdata     = wdata_q;
  assign bus.rgb_data      = rgb_q;
  assign bus.disp_bank     = bank;
  assign bus.frame_swapped = swp_q;
  assign bus.overrun       = ovr_q;

endmodule

// File: tb/tb_vga_fb_arbiter.sv
// Randomised bench for vga_fb_arbiter with a frame-buffer level reference
// model, a RAM behind the DUT and a few pinned literal scenarios.
module tb_vga_fb_arbiter;

  localparam int DW = 12;
  localparam int AW = 17;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  vga_fb_arbiter_if #(.DATA_W(DW), .ADDR_W(AW)) bus ();

  vga_fb_arbiter #(
    .DATA_W(DW), .FB_W(320), .FB_H(240), .ADDR_W(AW)
  ) dut (
    .clk(clk),
    .reset(reset),
    .bus(bus)
  );

  int tests = 0;
  int fails = 0;

  task automatic chk(input string nm, input logic [31:0] act,
                     input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // RAM seen by the DUT; returns junk whenever no read was issued.
  bit [11:0] ram [0:(1<<18)-1];
  bit        pre_done = 1'b0;
  always @(posedge clk) begin
    if (!pre_done) begin
      ram[965] <= 12'hABC;
      pre_done <= 1'b1;
    end
    if (bus.mem_en && bus.mem_we) ram[bus.mem_addr] <= bus.mem_wdata;
    bus.mem_rdata <= (bus.mem_en && !bus.mem_we) ? ram[bus.mem_addr]
                                                 : 12'($urandom);
  end

  // Reference model: expected frame-buffer contents and per-cycle outputs.
  typedef struct {
    int        due;
    bit        de;
    bit [17:0] a;
    bit [11:0] v;
  } rd_t;

  rd_t       rq[$];
  bit [11:0] ref_fb [0:(1<<18)-1];
  int        mcyc = 0;
  bit        chk_on = 1'b0;
  bit        m_bank, m_pend, m_vsq;
  bit        m_en, m_we, m_swp, m_ovr;
  bit [17:0] m_addr;
  bit [11:0] m_wdata, m_rgb;

  always @(posedge clk) begin
    bit rdy;
    bit fall;
    int pix;
    if (mcyc == 0) ref_fb[965] = 12'hABC;
    if (reset) begin
      m_bank = 0; m_pend = 0; m_vsq = 1;
      m_en = 0; m_we = 0; m_swp = 0; m_ovr = 0;
      m_addr = 0; m_wdata = 0; m_rgb = 0;
      rq.delete();
    end else begin
      if (rq.size() > 0 && rq[0].due == mcyc) begin
        m_rgb = rq[0].de ? rq[0].v : 12'h0;
        void'(rq.pop_front());
      end
      foreach (rq[i]) if (rq[i].due == mcyc + 1) rq[i].v = ref_fb[rq[i].a];
      rdy = !m_pend && !bus.pclk;
      m_en = 0; m_we = 0;
      if (bus.pclk) begin
        pix = (int'(bus.y_pixel) / 2) * 320 + int'(bus.x_pixel) / 2;
        rq.push_back('{mcyc + 2, bus.DE, {m_bank, 17'(pix)}, 12'h0});
        if (bus.DE) begin
          m_en = 1;
          m_addr = {m_bank, 17'(pix)};
        end
      end else if (bus.wr_valid && rdy && int'(bus.wr_addr) < 76800) begin
        m_en = 1; m_we = 1;
        m_addr = {!m_bank, bus.wr_addr};
        m_wdata = bus.wr_data;
        ref_fb[m_addr] = m_wdata;
      end
      fall = m_vsq && !bus.v_sync;
      m_swp = 0; m_ovr = 0;
      if (m_pend) begin
        m_ovr = bus.wr_frame_done;
        if (fall) begin
          m_bank = !m_bank; m_swp = 1; m_pend = 0;
        end
      end else if (bus.wr_frame_done) begin
        m_pend = 1;
      end
      m_vsq = bus.v_sync;
    end
    mcyc++;
    chk_on = 1'b1;
  end

  always @(negedge clk) begin
    if (chk_on) begin
      chk("wr_ready", bus.wr_ready, !reset && !bus.pclk && !m_pend);
      chk("mem_en", bus.mem_en, m_en);
      if (m_en) begin
        chk("mem_we", bus.mem_we, m_we);
        chk("mem_addr", bus.mem_addr, m_addr);
      end
      if (m_en && m_we) chk("mem_wdata", bus.mem_wdata, m_wdata);
      chk("rgb_data", bus.rgb_data, m_rgb);
      chk("disp_bank", bus.disp_bank, m_bank);
      chk("frame_swapped", bus.frame_swapped, m_swp);
      chk("overrun", bus.overrun, m_ovr);
    end
  end

  int ph = 3;

  task automatic cycle();
    @(posedge clk);
    #1;
    ph = (ph + 1) % 4;
    bus.pclk = (ph == 0);
  endtask

  int n;
  int vs_low;

  initial begin
    reset = 1'b1;
    bus.pclk = 0; bus.DE = 0; bus.x_pixel = 0; bus.y_pixel = 0;
    bus.v_sync = 1; bus.wr_valid = 1; bus.wr_addr = 3;
    bus.wr_data = 12'h123; bus.wr_frame_done = 0;
    repeat (3) cycle();
    chk("rst_mem_en", bus.mem_en, 0);
    chk("rst_bank", bus.disp_bank, 0);
    chk("rst_rgb", bus.rgb_data, 0);
    reset = 1'b0;
    while (bus.pclk) cycle();
    #1 chk("rel_ready", bus.wr_ready, 1);
    bus.wr_valid = 0;

    do cycle(); while (!bus.pclk);
    bus.DE = 1; bus.x_pixel = 10; bus.y_pixel = 7;
    cycle();
    chk("rd_en", bus.mem_en, 1);
    chk("rd_we", bus.mem_we, 0);
    chk("rd_addr", bus.mem_addr, 965);
    bus.DE = 0;
    cycle();
    cycle();
    chk("rd_rgb", bus.rgb_data, 12'hABC);
    do cycle(); while (!bus.pclk);
    repeat (3) cycle();
    chk("rgb_de0", bus.rgb_data, 0);

    do cycle(); while (!bus.pclk);
    bus.wr_valid = 1;
    n = 0;
    for (int i = 0; i < 12; i++) begin
      bus.wr_addr = 17'($urandom_range(0, 76799));
      bus.wr_data = 12'($urandom);
      cycle();
      if (bus.mem_we && bus.mem_addr[AW]) n++;
    end
    bus.wr_valid = 0;
    chk("burst_writes", n, 9);

    bus.wr_frame_done = 1;
    cycle();
    bus.wr_frame_done = 0;
    bus.wr_valid = 1;
    while (bus.pclk) cycle();
    #1 chk("pend_ready", bus.wr_ready, 0);
    bus.wr_frame_done = 1;
    cycle();
    bus.wr_frame_done = 0;
    chk("ovr_pulse", bus.overrun, 1);
    bus.v_sync = 0;
    cycle();
    chk("swap_bank", bus.disp_bank, 1);
    chk("swap_pulse", bus.frame_swapped, 1);
    cycle();
    chk("swap_once", bus.frame_swapped, 0);
    bus.wr_valid = 0;
    while (bus.pclk) cycle();
    bus.wr_valid = 1; bus.wr_addr = 100; bus.wr_data = 12'h5A5;
    #1 chk("swap_ready", bus.wr_ready, 1);
    cycle();
    bus.wr_valid = 0; bus.v_sync = 1;
    chk("post_swap_we", bus.mem_we, 1);
    chk("post_swap_bank", bus.mem_addr[AW], 0);

    while (bus.pclk) cycle();
    bus.wr_valid = 1; bus.wr_addr = 76800;
    cycle();
    bus.wr_valid = 0;
    chk("oob_no_en", bus.mem_en, 0);

    while (bus.pclk) cycle();
    bus.wr_valid = 1; bus.wr_addr = 7;
    cycle();
    bus.wr_valid = 0;
    reset = 1;
    chk("pre_rst_we", bus.mem_we, 1);
    cycle();
    reset = 0;
    chk("rst_drop_we", bus.mem_we, 0);
    chk("rst_drop_bank", bus.disp_bank, 0);

    vs_low = 0;
    for (int i = 0; i < 3000; i++) begin
      cycle();
      reset = ($urandom_range(0, 999) == 0);
      bus.DE = ($urandom_range(0, 9) < 8);
      bus.x_pixel = 10'($urandom_range(0, 639));
      bus.y_pixel = 10'($urandom_range(0, 479));
      bus.wr_valid = ($urandom_range(0, 9) < 7);
      bus.wr_addr = ($urandom_range(0, 19) == 0) ?
                    17'($urandom_range(76800, 131071)) :
                    17'($urandom_range(0, 76799));
      bus.wr_data = 12'($urandom);
      bus.wr_frame_done = ($urandom_range(0, 119) == 0);
      if (vs_low > 0) begin
        vs_low--;
        bus.v_sync = 0;
      end else begin
        bus.v_sync = 1;
        if ($urandom_range(0, 299) == 0) vs_low = 5;
      end
    end
    cycle();
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
